pc_fetch_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer for the single-cycle RISC-V core. It sits directly downstream of the next-PC select mux: it registers the selected next PC when the current instruction retires, then fetches the word at that PC over a request/grant/response instruction-memory interface. It presents the instruction to decode and provides `pc` and `pc_plus_4` back to the next-PC mux and the branch/jump adders. Misaligned control-transfer targets raise a sticky fault that halts fetch.

---
 rtl/pc_fetch_unit.sv | 115 +++++++++++
 tb/tb_pc_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: holds the PC, fetches the
// word at it over a req/gnt/rvalid port, and counts retired instructions.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        retire,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misaligned_fault,
  output logic [31:0] instret
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   instret_q, instret_d;
  logic              fault_q, fault_d;
  logic              retire_ok;
  logic              target_ok;

  // Retire only counts while an instruction is actually presented.
  assign retire_ok = (state_q == ST_HOLD) && retire;
  assign target_ok = (next_pc[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_REQ;
      ST_REQ:   if (imem_gnt)    state_d = ST_WAIT;
      ST_WAIT:  if (imem_rvalid) state_d = ST_HOLD;
      ST_HOLD:  if (retire)      state_d = target_ok ? ST_REQ : ST_FAULT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      ST_REQ:  imem_req    = 1'b1;
      ST_HOLD: instr_valid = 1'b1;
      default: ;
    endcase
  end

  // A misaligned target still retires its instruction but never becomes the PC.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    fault_d   = fault_q;
    if ((state_q == ST_WAIT) && imem_rvalid) begin
      instr_d = imem_rdata;
    end
    if (retire_ok) begin
      instret_d = instret_q + XLEN'(1);
      if (target_ok) begin
        pc_d = next_pc;
      end else begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      instret_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      fault_q   <= fault_d;
    end
  end

  assign pc               = pc_q;
  assign pc_plus_4        = pc_q + XLEN'(4);
  assign imem_addr        = pc_q;
  assign instr            = instr_q;
  assign misaligned_fault = fault_q;
  assign instret          = instret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        retire;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misaligned_fault;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .next_pc          (next_pc),
    .retire           (retire),
    .pc               (pc),
    .pc_plus_4        (pc_plus_4),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .misaligned_fault (misaligned_fault),
    .instret          (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: tracks what the fetcher is doing in protocol terms.
  logic        m_boot = 1'b1;
  logic        m_req  = 1'b0;
  logic        m_out  = 1'b0;
  logic        m_have = 1'b0;
  logic        m_fault = 1'b0;
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_instret = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot = 1'b1; m_req = 1'b0; m_out = 1'b0; m_have = 1'b0;
      m_fault = 1'b0; m_pc = RST_PC; m_instr = 32'h0; m_instret = 32'h0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_req  = 1'b1;
    end else if (m_req) begin
      if (imem_gnt) begin
        m_req = 1'b0;
        m_out = 1'b1;
      end
    end else if (m_out) begin
      if (imem_rvalid) begin
        m_out   = 1'b0;
        m_instr = imem_rdata;
        m_have  = 1'b1;
      end
    end else if (m_have && retire) begin
      m_have    = 1'b0;
      m_instret = m_instret + 32'd1;
      if (next_pc % 4 == 0) begin
        m_pc  = next_pc;
        m_req = 1'b1;
      end else begin
        m_fault = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_pc",        pc,                        m_pc);
    chk("cyc_pc4",       pc_plus_4,                 m_pc + 32'd4);
    chk("cyc_addr",      imem_addr,                 m_pc);
    chk("cyc_req",       32'(imem_req),             32'(m_req));
    chk("cyc_valid",     32'(instr_valid),          32'(m_have));
    chk("cyc_instr",     instr,                     m_instr);
    chk("cyc_fault",     32'(misaligned_fault),     32'(m_fault));
    chk("cyc_instret",   instret,                   m_instret);
  end

  task automatic step(input logic g, input logic rv, input logic rt,
                      input logic [31:0] np, input logic [31:0] rd);
    imem_gnt    = g;
    imem_rvalid = rv;
    retire      = rt;
    next_pc     = np;
    imem_rdata  = rd;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; retire = 1'b0;
    next_pc = 32'h0; imem_rdata = 32'h0;
    rst_n = 1'b0;
    #1;
    chk("rst_pc",      pc,                    RST_PC);
    chk("rst_valid",   32'(instr_valid),      32'h0);
    chk("rst_req",     32'(imem_req),         32'h0);
    chk("rst_instr",   instr,                 32'h0);
    chk("rst_fault",   32'(misaligned_fault), 32'h0);
    chk("rst_instret", instret,               32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; retire = 1'b0;
    next_pc = 32'h0; imem_rdata = 32'h0;
    @(posedge clk);
    #1;
    do_reset();

    // Back-to-back zero-wait fetches with sequential retire.
    step(0, 0, 0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("seq_req",  32'(imem_req), 32'h1);
      chk("seq_addr", imem_addr,     32'(4 * k));
      step(1, 0, 0, 32'h0, 32'h0);
      step(0, 1, 0, 32'h0, 32'h0000_0013);
      chk("seq_valid",     32'(instr_valid), 32'h1);
      chk("seq_valid_cyc", 32'(cyc),         32'(3 * k + 3));
      chk("seq_instr",     instr,            32'h0000_0013);
      step(0, 0, 1, pc_plus_4, 32'h0);
    end
    chk("seq_instret", instret, 32'd3);
    chk("seq_pc",      pc,      32'h0000_000C);

    // Grant withheld 4 cycles, with stray rvalid/retire while requesting.
    for (int k = 0; k < 4; k++) begin
      chk("stall_req",  32'(imem_req),    32'h1);
      chk("stall_addr", imem_addr,        32'h0000_000C);
      step(0, (k == 1), (k == 2), 32'h0000_0040, 32'hBAD0_0BAD);
      chk("stall_pc",    pc,               32'h0000_000C);
      chk("stall_valid", 32'(instr_valid), 32'h0);
      chk("stall_instr", instr,            32'h0000_0013);
    end
    chk("stall_req5",  32'(imem_req), 32'h1);
    chk("stall_addr5", imem_addr,     32'h0000_000C);
    step(1, 0, 0, 32'h0, 32'h0);
    step(0, 0, 1, 32'h0000_0040, 32'h0);
    chk("wait_retire_pc",      pc,      32'h0000_000C);
    chk("wait_retire_instret", instret, 32'd3);
    chk("wait_valid",          32'(instr_valid), 32'h0);
    step(0, 1, 0, 32'h0, 32'hABCD_0093);
    chk("stall_instr_new", instr, 32'hABCD_0093);

    // Jump to 0x100.
    step(0, 0, 1, 32'h0000_0100, 32'h0);
    chk("jmp_pc",      pc,               32'h0000_0100);
    chk("jmp_pc4",     pc_plus_4,        32'h0000_0104);
    chk("jmp_addr",    imem_addr,        32'h0000_0100);
    chk("jmp_req",     32'(imem_req),    32'h1);
    chk("jmp_valid",   32'(instr_valid), 32'h0);
    chk("jmp_instret", instret,          32'd4);

    // Jump to the top word: pc_plus_4 wraps to zero.
    step(1, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 32'h0, 32'h0000_0517);
    step(0, 0, 1, 32'hFFFF_FFFC, 32'h0);
    chk("wrap_pc",  pc,        32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus_4, 32'h0000_0000);

    // Misaligned target: sticky fault, fetch halted.
    step(1, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 32'h0, 32'h0000_006F);
    step(0, 0, 1, 32'h0000_0102, 32'h0);
    chk("flt_fault",   32'(misaligned_fault), 32'h1);
    chk("flt_req",     32'(imem_req),         32'h0);
    chk("flt_pc",      pc,                    32'hFFFF_FFFC);
    chk("flt_instret", instret,               32'd6);
    for (int k = 0; k < 4; k++) begin
      step((k == 0), (k == 1), 1'b1, 32'h0000_0200, 32'h1234_5678);
      chk("flt_sticky",   32'(misaligned_fault), 32'h1);
      chk("flt_req_hold", 32'(imem_req),         32'h0);
      chk("flt_valid",    32'(instr_valid),      32'h0);
      chk("flt_inst_hold", instret,              32'd6);
    end

    // Reset clears the fault; then reset mid-WAIT with a late rvalid.
    do_reset();
    step(0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    do_reset();
    step(0, 1, 0, 32'h0, 32'hDEAD_BEEF);
    chk("late_req",   32'(imem_req),    32'h1);
    chk("late_addr",  imem_addr,        RST_PC);
    chk("late_instr", instr,            32'h0);
    chk("late_valid", 32'(instr_valid), 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 32'h0, 32'h0000_0033);
    chk("fresh_valid", 32'(instr_valid), 32'h1);
    chk("fresh_instr", instr,            32'h0000_0033);
    chk("fresh_cyc",   32'(cyc),         32'd3);
    step(0, 0, 0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
